mxu_gen: RTL and testbench

Parametrised matrix-multiply unit: computes C = A × B for SIZE×SIZE operand matrices on an internal output-stationary systolic array of SIZE×SIZE multiply-accumulate PEs. It succeeds the fixed 8-bit/32-bit unit with configurable operand and accumulator widths, per-job signed/unsigned mode, multi-tile accumulation and a registered result bank with a valid flag. It sits between the host-side operand staging logic and the result readback path.

---
 rtl/mxu_gen_if.sv | 26 ++
 rtl/mxu_gen.sv | 168 ++++++++++++++++
 tb/tb_mxu_gen.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mxu_gen_if.sv
// Job request / result bus of the matrix-multiply unit.
interface mxu_gen_if #(
   parameter int unsigned SIZE   = 4,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ACC_W  = 32
);
   logic                         start_in;
   logic                         accum_in;
   logic                         signed_in;
   logic [SIZE*SIZE*DATA_W-1:0]  data_a_in;
   logic [SIZE*SIZE*DATA_W-1:0]  data_b_in;
   logic                         busy_o;
   logic                         done_o;
   logic                         d_valid_o;
   logic [SIZE*SIZE*ACC_W-1:0]   d_out;

   modport master (
      output start_in, accum_in, signed_in, data_a_in, data_b_in,
      input  busy_o, done_o, d_valid_o, d_out
   );

   modport slave (
      input  start_in, accum_in, signed_in, data_a_in, data_b_in,
      output busy_o, done_o, d_valid_o, d_out
   );
endinterface

// File: rtl/mxu_gen.sv
// Output-stationary SIZE x SIZE systolic matrix multiply, C = A*B (+ previous C).
// Optional MXU_SAT_EN: saturating accumulation instead of modulo wrap.
module mxu_gen #(
   parameter int unsigned SIZE   = 4,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ACC_W  = 32
) (
   input  logic       clk,
   input  logic       reset,
   mxu_gen_if.slave   bus
);
   localparam int unsigned PW    = 2 * DATA_W;
   localparam int unsigned LAST  = 3 * SIZE - 3;
   localparam int unsigned CNT_W = $clog2(LAST + 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t                     state_q, state_d;
   logic [CNT_W-1:0]           step_q;
   logic                       busy_q, busy_d, done_q, done_d, valid_q, valid_d;
   logic                       accept, accum_q, sgn_q;
   logic [DATA_W-1:0]          a_m   [SIZE][SIZE];
   logic [DATA_W-1:0]          b_m   [SIZE][SIZE];
   logic [DATA_W-1:0]          a_reg [SIZE][SIZE-1];
   logic [DATA_W-1:0]          b_reg [SIZE-1][SIZE];
   logic [DATA_W-1:0]          a_op  [SIZE][SIZE];
   logic [DATA_W-1:0]          b_op  [SIZE][SIZE];
   logic [ACC_W-1:0]           acc_q [SIZE][SIZE];
   logic [ACC_W-1:0]           acc_sum [SIZE][SIZE];
   logic [SIZE*SIZE*ACC_W-1:0] d_q;

   // Exact product, sign- or zero-extended to the accumulator width.
   function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic sg);
      logic [PW-1:0] ae, be, p;
      ae = sg ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
      be = sg ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
      p  = ae * be;
      if (sg) return ACC_W'($signed(p));
      return ACC_W'(p);
   endfunction

`ifdef MXU_SAT_EN
   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] x,
                                                input logic [ACC_W-1:0] y,
                                                input logic sg);
      logic [ACC_W:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (sg) begin
         if (x[ACC_W-1] == y[ACC_W-1] && s[ACC_W-1] != x[ACC_W-1])
            return x[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
         return s[ACC_W-1:0];
      end
      return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
   endfunction
`endif

   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      valid_d = valid_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: if (bus.start_in) begin
            accept  = 1'b1;
            busy_d  = 1'b1;
            valid_d = 1'b0;
            state_d = LOAD;
         end
         LOAD: state_d = RUN;
         RUN:  if (step_q == CNT_W'(LAST)) state_d = DONE;
         DONE: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Skewed edge injection plus one-hop right/down operand propagation.
   always_comb begin
      a_op = '{default: '0};
      b_op = '{default: '0};
      for (int r = 0; r < SIZE; r++)
         for (int k = 0; k < SIZE; k++)
            if (int'(step_q) == r + k) begin
               a_op[r][0] = a_m[r][k];
               b_op[0][r] = b_m[k][r];
            end
      for (int r = 0; r < SIZE; r++)
         for (int c = 1; c < SIZE; c++) begin
            a_op[r][c] = a_reg[r][c-1];
            b_op[c][r] = b_reg[c-1][r];
         end
      for (int r = 0; r < SIZE; r++)
         for (int c = 0; c < SIZE; c++)
`ifdef MXU_SAT_EN
            acc_sum[r][c] = sat_add(acc_q[r][c], mul_ext(a_op[r][c], b_op[r][c], sgn_q), sgn_q);
`else
            acc_sum[r][c] = acc_q[r][c] + mul_ext(a_op[r][c], b_op[r][c], sgn_q);
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         step_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         accum_q <= 1'b0;
         sgn_q   <= 1'b0;
         a_m     <= '{default: '0};
         b_m     <= '{default: '0};
         a_reg   <= '{default: '0};
         b_reg   <= '{default: '0};
         acc_q   <= '{default: '0};
         d_q     <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         if (accept) begin
            accum_q <= bus.accum_in;
            sgn_q   <= bus.signed_in;
            for (int r = 0; r < SIZE; r++)
               for (int c = 0; c < SIZE; c++) begin
                  a_m[r][c] <= bus.data_a_in[(r*SIZE+c)*DATA_W +: DATA_W];
                  b_m[r][c] <= bus.data_b_in[(r*SIZE+c)*DATA_W +: DATA_W];
               end
         end
         case (state_q)
            LOAD: begin
               step_q <= '0;
               a_reg  <= '{default: '0};
               b_reg  <= '{default: '0};
               for (int r = 0; r < SIZE; r++)
                  for (int c = 0; c < SIZE; c++)
                     acc_q[r][c] <= accum_q ? d_q[(r*SIZE+c)*ACC_W +: ACC_W] : '0;
            end
            RUN: begin
               step_q <= step_q + CNT_W'(1);
               acc_q  <= acc_sum;
               for (int r = 0; r < SIZE; r++)
                  for (int c = 0; c < SIZE - 1; c++) begin
                     a_reg[r][c] <= a_op[r][c];
                     b_reg[c][r] <= b_op[c][r];
                  end
            end
            DONE:
               for (int r = 0; r < SIZE; r++)
                  for (int c = 0; c < SIZE; c++)
                     d_q[(r*SIZE+c)*ACC_W +: ACC_W] <= acc_q[r][c];
            default: ;
         endcase
      end
   end

   assign bus.busy_o    = busy_q;
   assign bus.done_o    = done_q;
   assign bus.d_valid_o = valid_q;
   assign bus.d_out     = d_q;
endmodule

// File: tb/tb_mxu_gen.sv
// Scoreboard bench for mxu_gen: a 32-bit accumulator unit and a 16-bit one.
module tb_mxu_gen;
   logic clk, rst_n;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_err = 0;

   typedef struct { logic [511:0] d; int cyc; } exp_t;
   exp_t q32[$];
   exp_t q16[$];

   mxu_gen_if #(.SIZE(4), .DATA_W(8), .ACC_W(32)) b32 ();
   mxu_gen_if #(.SIZE(4), .DATA_W(8), .ACC_W(16)) b16 ();

   mxu_gen #(.SIZE(4), .DATA_W(8), .ACC_W(32)) dut32 (.clk(clk), .reset(rst_n), .bus(b32));
   mxu_gen #(.SIZE(4), .DATA_W(8), .ACC_W(16)) dut16 (.clk(clk), .reset(rst_n), .bus(b16));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_err);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic logic [127:0] fill8(input logic [7:0] v);
      logic [127:0] m;
      for (int i = 0; i < 16; i++) m[i*8 +: 8] = v;
      return m;
   endfunction

   function automatic logic [127:0] ident8();
      logic [127:0] m;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) m[(r*4+c)*8 +: 8] = (r == c) ? 8'd1 : 8'd0;
      return m;
   endfunction

   function automatic logic [127:0] seq8();
      logic [127:0] m;
      for (int i = 0; i < 16; i++) m[i*8 +: 8] = 8'(i);
      return m;
   endfunction

   function automatic logic [511:0] fill32(input logic [31:0] v);
      logic [511:0] m;
      for (int i = 0; i < 16; i++) m[i*32 +: 32] = v;
      return m;
   endfunction

   function automatic logic [511:0] ident32(input logic [31:0] v);
      logic [511:0] m;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) m[(r*4+c)*32 +: 32] = (r == c) ? v : 32'd0;
      return m;
   endfunction

   function automatic logic [511:0] seq32();
      logic [511:0] m;
      for (int i = 0; i < 16; i++) m[i*32 +: 32] = 32'(i);
      return m;
   endfunction

   function automatic logic [511:0] fill16(input logic [15:0] v);
      logic [511:0] m;
      m = '0;
      for (int i = 0; i < 16; i++) m[i*16 +: 16] = v;
      return m;
   endfunction

   // Called on a falling edge; returns on the falling edge after the acceptance edge.
   task automatic issue(input bit sel, input bit acc, input bit sg,
                        input logic [127:0] a, input logic [127:0] b,
                        input logic [511:0] expv, input bit push);
      if (sel) begin
         b16.accum_in = acc; b16.signed_in = sg; b16.data_a_in = a; b16.data_b_in = b;
         b16.start_in = 1'b1;
      end else begin
         b32.accum_in = acc; b32.signed_in = sg; b32.data_a_in = a; b32.data_b_in = b;
         b32.start_in = 1'b1;
      end
      @(negedge clk);
      b32.start_in = 1'b0;
      b16.start_in = 1'b0;
      if (sel) begin
         chk("busy16_after_accept", 512'(b16.busy_o), 512'(1));
         chk("valid16_cleared", 512'(b16.d_valid_o), 512'(0));
         if (push) q16.push_back('{expv, cyc + 12});
      end else begin
         chk("busy32_after_accept", 512'(b32.busy_o), 512'(1));
         chk("valid32_cleared", 512'(b32.d_valid_o), 512'(0));
         if (push) q32.push_back('{expv, cyc + 12});
      end
   endtask

   task automatic wait_idle(input bit sel);
      int n;
      n = 0;
      while ((sel ? b16.busy_o : b32.busy_o) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_checks++;
         n_err++;
         $display("FAIL wait_idle%0d: busy still 1 after %0d cycles, required 0", sel ? 16 : 32, n);
      end
      @(negedge clk);
   endtask

   always @(negedge clk) begin : mon32
      exp_t e;
      if (b32.done_o) begin
         if (q32.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL done32_unexpected: done_o=1 at cycle %0d, required no pulse", cyc);
         end else begin
            e = q32.pop_front();
            chk("d_out32", b32.d_out, e.d);
            chk("latency32", 512'(cyc), 512'(e.cyc));
            chk("d_valid32", 512'(b32.d_valid_o), 512'(1));
            chk("busy32_at_done", 512'(b32.busy_o), 512'(0));
         end
      end
   end

   always @(negedge clk) begin : mon16
      exp_t e;
      if (b16.done_o) begin
         if (q16.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL done16_unexpected: done_o=1 at cycle %0d, required no pulse", cyc);
         end else begin
            e = q16.pop_front();
            chk("d_out16", 512'(b16.d_out), e.d);
            chk("latency16", 512'(cyc), 512'(e.cyc));
            chk("d_valid16", 512'(b16.d_valid_o), 512'(1));
         end
      end
   end

   initial begin
      int c0;
      rst_n = 1'b0;
      b32.start_in = 1'b0; b32.accum_in = 1'b0; b32.signed_in = 1'b0;
      b32.data_a_in = '0;  b32.data_b_in = '0;
      b16.start_in = 1'b0; b16.accum_in = 1'b0; b16.signed_in = 1'b0;
      b16.data_a_in = '0;  b16.data_b_in = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 512'(b32.busy_o), 512'(0));
      chk("reset_done", 512'(b32.done_o), 512'(0));
      chk("reset_valid", 512'(b32.d_valid_o), 512'(0));
      chk("reset_d_out", b32.d_out, 512'(0));
      chk("reset_valid16", 512'(b16.d_valid_o), 512'(0));
      rst_n = 1'b1;
      @(negedge clk);

      issue(0, 0, 0, ident8(), seq8(), seq32(), 1);                          wait_idle(0);
      issue(0, 0, 1, fill8(8'hFF), fill8(8'h02), fill32(32'hFFFF_FFF8), 1); wait_idle(0);
      issue(0, 0, 0, fill8(8'hFF), fill8(8'h02), fill32(32'd2040), 1);      wait_idle(0);
      issue(0, 0, 0, ident8(), ident8(), ident32(32'd1), 1);                 wait_idle(0);
      issue(0, 1, 0, ident8(), ident8(), ident32(32'd2), 1);                 wait_idle(0);
      issue(0, 0, 0, ident8(), ident8(), ident32(32'd1), 1);                 wait_idle(0);

      // Second start mid-job with different operands must be dropped.
      issue(0, 0, 0, ident8(), seq8(), seq32(), 1);
      repeat (4) @(negedge clk);
      b32.signed_in = 1'b1; b32.data_a_in = fill8(8'hFF); b32.data_b_in = fill8(8'h02);
      b32.start_in = 1'b1;
      @(negedge clk);
      b32.start_in = 1'b0;
      chk("d_out_held_midjob", b32.d_out, ident32(32'd1));
      chk("busy_midjob", 512'(b32.busy_o), 512'(1));
      wait_idle(0);

      // Reset at RUN step 3 aborts the job.
      issue(0, 0, 0, ident8(), seq8(), '0, 0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", 512'(b32.busy_o), 512'(0));
      chk("abort_valid", 512'(b32.d_valid_o), 512'(0));
      chk("abort_d_out", b32.d_out, 512'(0));
      chk("abort_done", 512'(b32.done_o), 512'(0));
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      issue(0, 1, 0, ident8(), ident8(), ident32(32'd1), 1);                 wait_idle(0);

      // start_in held high: second job accepted in the IDLE cycle after done_o.
      b32.accum_in = 1'b0; b32.signed_in = 1'b0;
      b32.data_a_in = ident8(); b32.data_b_in = seq8();
      b32.start_in = 1'b1;
      @(negedge clk);
      c0 = cyc;
      q32.push_back('{seq32(), c0 + 12});
      q32.push_back('{fill32(32'd60), c0 + 25});
      b32.data_a_in = fill8(8'd3); b32.data_b_in = fill8(8'd5);
      repeat (13) @(negedge clk);
      b32.start_in = 1'b0;
      chk("b2b_second_accept", 512'(b32.busy_o), 512'(1));
      wait_idle(0);

`ifdef MXU_SAT_EN
      issue(1, 0, 0, fill8(8'hFF), fill8(8'hFF), fill16(16'd65535), 1);     wait_idle(1);
      issue(1, 0, 1, fill8(8'h80), fill8(8'h80), fill16(16'd32767), 1);     wait_idle(1);
`else
      issue(1, 0, 0, fill8(8'hFF), fill8(8'hFF), fill16(16'd63492), 1);     wait_idle(1);
      issue(1, 0, 1, fill8(8'h80), fill8(8'h80), fill16(16'd0), 1);         wait_idle(1);
`endif

      repeat (2) @(negedge clk);
      chk("pending32", 512'(q32.size()), 512'(0));
      chk("pending16", 512'(q16.size()), 512'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
